// File: rtl/layer_controller_if.sv
// Handshake and control bundle between layer_controller and its surroundings.
// master: the controller side; slave: network FSM / datapath side.
interface layer_controller_if #(
    parameter int SEL_W = 32
);
    logic             start;
    logic             in_valid;
    logic             ready;
    logic             rst_Acc;
    logic             ld_Acc;
    logic             ld_bias;
    logic             wr_out;
    logic             done;
    logic [SEL_W-1:0] input_sel;
    logic [SEL_W-1:0] neuron_sel;

    modport master (
        input  start, in_valid,
        output ready, rst_Acc, ld_Acc, ld_bias, wr_out, done, input_sel, neuron_sel
    );

    modport slave (
        output start, in_valid,
        input  ready, rst_Acc, ld_Acc, ld_bias, wr_out, done, input_sel, neuron_sel
    );
endinterface

// File: rtl/layer_controller.sv
// Fully-connected layer sequencer: per neuron clear accumulator, feed N_IN inputs, store.
// Optional BIAS_LOAD_EN macro inserts a one-cycle bias-load state after each clear.
module layer_controller #(
    parameter int N_IN  = 10,
    parameter int N_OUT = 4,
    parameter int SEL_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    layer_controller_if.master    bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RSTS  = 3'd1;
`ifdef BIAS_LOAD_EN
    localparam logic [2:0] S_BIAS  = 3'd2;
`endif
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [SEL_W-1:0] IN_LAST  = SEL_W'(N_IN - 1);
    localparam logic [SEL_W-1:0] OUT_LAST = SEL_W'(N_OUT - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [SEL_W-1:0] input_sel_r;
    logic [SEL_W-1:0] input_sel_s;
    logic [SEL_W-1:0] neuron_sel_r;
    logic [SEL_W-1:0] neuron_sel_s;

    // Next-state and counter update; counters only ever compare against terminal count.
    always_comb begin
        state_s      = state_r;
        input_sel_s  = input_sel_r;
        neuron_sel_s = neuron_sel_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_s = S_RSTS;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RSTS: begin
                input_sel_s = {SEL_W{1'b0}};
`ifdef BIAS_LOAD_EN
                state_s     = S_BIAS;
`else
                state_s     = S_CALC;
`endif
            end
`ifdef BIAS_LOAD_EN
            S_BIAS: begin
                input_sel_s = {SEL_W{1'b0}};
                state_s     = S_CALC;
            end
`endif
            S_CALC: begin
                if (!bus.in_valid) begin
                    state_s = S_CALC;
                end else if (input_sel_r == IN_LAST) begin
                    state_s = S_STORE;
                end else begin
                    input_sel_s = input_sel_r + SEL_ONE;
                end
            end
            S_STORE: begin
                if (neuron_sel_r == OUT_LAST) begin
                    state_s = S_DONE;
                end else begin
                    neuron_sel_s = neuron_sel_r + SEL_ONE;
                    input_sel_s  = {SEL_W{1'b0}};
                    state_s      = S_RSTS;
                end
            end
            S_DONE: begin
                input_sel_s  = {SEL_W{1'b0}};
                neuron_sel_s = {SEL_W{1'b0}};
                state_s      = S_IDLE;
            end
            // Unused encodings recover to a clean idle
            default: begin
                input_sel_s  = {SEL_W{1'b0}};
                neuron_sel_s = {SEL_W{1'b0}};
                state_s      = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            input_sel_r  <= {SEL_W{1'b0}};
            neuron_sel_r <= {SEL_W{1'b0}};
        end else begin
            state_r      <= state_s;
            input_sel_r  <= input_sel_s;
            neuron_sel_r <= neuron_sel_s;
        end
    end

    assign bus.ready      = (state_r == S_IDLE);
    assign bus.rst_Acc    = (state_r == S_RSTS);
    assign bus.ld_Acc     = (state_r == S_CALC) && bus.in_valid;
    assign bus.wr_out     = (state_r == S_STORE);
    assign bus.done       = (state_r == S_DONE);
    assign bus.input_sel  = input_sel_r;
    assign bus.neuron_sel = neuron_sel_r;
`ifdef BIAS_LOAD_EN
    assign bus.ld_bias    = (state_r == S_BIAS);
`else
    assign bus.ld_bias    = 1'b0;
`endif
endmodule

// File: tb/tb_layer_controller.sv
// Directed bench for layer_controller: a 3x2 layer and a 1x1 boundary layer.
module tb_layer_controller;
`ifdef BIAS_LOAD_EN
    localparam int          BIAS_CYC    = 1;
    localparam logic [31:0] EXP_B_TRACE = 32'h00123456;
`else
    localparam int          BIAS_CYC    = 0;
    localparam logic [31:0] EXP_B_TRACE = 32'h00013456;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    layer_controller_if #(.SEL_W(32)) a_if ();
    layer_controller_if #(.SEL_W(32)) b_if ();

    layer_controller #(.N_IN(3), .N_OUT(2), .SEL_W(32)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    layer_controller #(.N_IN(1), .N_OUT(1), .SEL_W(32)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One layer run on dut_a; stall_len in_valid=0 cycles at neuron 0, input_sel 1.
    task automatic run_a(input string tag, input int stall_len, input bit hold_start,
                         input int exp_done);
        int cyc, done_cyc, stall_left, n_rst, n_bias, n_ld, n_wr, bad_excl, bad_ready, bad_stall;
        int guard;
        bit stalled;
        logic [31:0] ld_pack, wr_pack;
        cyc = 1; done_cyc = 0; stall_left = 0; stalled = 1'b0;
        n_rst = 0; n_bias = 0; n_ld = 0; n_wr = 0;
        bad_excl = 0; bad_ready = 0; bad_stall = 0;
        ld_pack = 32'd0; wr_pack = 32'd0;
        a_if.start = 1'b1;
        a_if.in_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) a_if.start = 1'b0;
        while (done_cyc == 0 && cyc < 60) begin
            if (!stalled && stall_len > 0 && a_if.input_sel == 32'd1 && a_if.neuron_sel == 32'd0) begin
                stalled = 1'b1;
                stall_left = stall_len;
            end
            a_if.in_valid = (stall_left > 0) ? 1'b0 : 1'b1;
            #1;
            if (stall_left > 0) begin
                if (a_if.ld_Acc || a_if.input_sel != 32'd1) bad_stall++;
                stall_left--;
            end
            if (32'(a_if.rst_Acc) + 32'(a_if.ld_bias) + 32'(a_if.ld_Acc)
                + 32'(a_if.wr_out) + 32'(a_if.done) > 32'd1) bad_excl++;
            if (a_if.ready) bad_ready++;
            if (a_if.rst_Acc) n_rst++;
            if (a_if.ld_bias) n_bias++;
            if (a_if.ld_Acc) begin
                n_ld++;
                ld_pack = (ld_pack << 4) | ((a_if.input_sel + 32'd1) & 32'hF);
            end
            if (a_if.wr_out) begin
                n_wr++;
                wr_pack = (wr_pack << 4) | ((a_if.neuron_sel + 32'd1) & 32'hF);
            end
            if (a_if.done) done_cyc = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        a_if.in_valid = 1'b1;
        check_eq({tag, "_done_cycle"}, done_cyc, exp_done);
        check_eq({tag, "_n_rst_acc"}, n_rst, 32'd2);
        check_eq({tag, "_n_ld_bias"}, n_bias, 2 * BIAS_CYC);
        check_eq({tag, "_n_ld_acc"}, n_ld, 32'd6);
        check_eq({tag, "_ld_sel_seq"}, ld_pack, 32'h00123123);
        check_eq({tag, "_n_wr_out"}, n_wr, 32'd2);
        check_eq({tag, "_wr_sel_seq"}, wr_pack, 32'h00000012);
        check_eq({tag, "_strobe_excl"}, bad_excl, 32'd0);
        check_eq({tag, "_ready_low"}, bad_ready, 32'd0);
        check_eq({tag, "_stall_hold"}, bad_stall, 32'd0);
        check_eq({tag, "_ready_after"}, 32'(a_if.ready), 32'd1);
        check_eq({tag, "_sels_cleared"}, a_if.input_sel | a_if.neuron_sel, 32'd0);
        if (hold_start) begin
            @(posedge clk); #1;
            check_eq({tag, "_relaunch"}, 32'(a_if.rst_Acc), 32'd1);
            a_if.start = 1'b0;
            guard = 0;
            while (!a_if.ready && guard < 60) begin
                @(posedge clk); #1;
                guard++;
            end
            check_eq({tag, "_relaunch_idle"}, 32'(a_if.ready), 32'd1);
        end
    endtask

    initial begin
        int guard, n_bad, cyc, done_cyc;
        logic [31:0] trace;
        a_if.start = 1'b0; a_if.in_valid = 1'b0;
        b_if.start = 1'b0; b_if.in_valid = 1'b0;

        // Reset for two edges, then release
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_ready", 32'(a_if.ready), 32'd1);
        check_eq("rst_strobes", {27'd0, a_if.rst_Acc, a_if.ld_Acc, a_if.ld_bias, a_if.wr_out, a_if.done}, 32'd0);
        check_eq("rst_input_sel", a_if.input_sel, 32'd0);
        check_eq("rst_neuron_sel", a_if.neuron_sel, 32'd0);
        check_eq("rst_b_ready", 32'(b_if.ready), 32'd1);
        @(posedge clk); #1;

        run_a("plain", 0, 1'b0, 11 + 2 * BIAS_CYC);
        run_a("stall", 2, 1'b0, 13 + 2 * BIAS_CYC);
        run_a("hold", 0, 1'b1, 11 + 2 * BIAS_CYC);

        // Abort in CALC of neuron 1
        a_if.start = 1'b1; a_if.in_valid = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        guard = 0;
        while (!(a_if.ld_Acc && a_if.neuron_sel == 32'd1) && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("abort_reach_calc1", 32'(guard < 60), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_ready", 32'(a_if.ready), 32'd1);
        check_eq("abort_sels", a_if.input_sel | a_if.neuron_sel, 32'd0);
        check_eq("abort_ld_acc", 32'(a_if.ld_Acc), 32'd0);
        n_bad = 0;
        repeat (4) begin
            if (a_if.done || a_if.wr_out) n_bad++;
            @(posedge clk); #1;
        end
        check_eq("abort_no_strobes", n_bad, 32'd0);
        run_a("restart", 0, 1'b0, 11 + 2 * BIAS_CYC);

        // Single-input single-neuron layer: strobe trace per cycle
        b_if.start = 1'b1; b_if.in_valid = 1'b1;
        @(posedge clk); #1;
        b_if.start = 1'b0;
        trace = 32'd0; done_cyc = 0; cyc = 1;
        while (done_cyc == 0 && cyc < 20) begin
            if (b_if.rst_Acc)      trace = (trace << 4) | 32'd1;
            else if (b_if.ld_bias) trace = (trace << 4) | 32'd2;
            else if (b_if.ld_Acc)  trace = (trace << 4) | 32'd3;
            else if (b_if.wr_out)  trace = (trace << 4) | 32'd4;
            else if (b_if.done)    trace = (trace << 4) | 32'd5;
            else if (b_if.ready)   trace = (trace << 4) | 32'd6;
            else                   trace = (trace << 4);
            if (b_if.done) done_cyc = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        if (b_if.ready) trace = (trace << 4) | 32'd6;
        check_eq("b_done_cycle", done_cyc, 4 + BIAS_CYC);
        check_eq("b_trace", trace, EXP_B_TRACE);
        check_eq("b_sels", b_if.input_sel | b_if.neuron_sel, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
